adder_csr_bank: RTL and testbench
=================================

Name: adder_csr_bank

Overview:
- Parametrised successor to the adder's control/status register file.
- Holds N_OPS operand registers, a result register, CTRL, STATUS and ID registers. All are reachable over the simple AMBA-style read/write channel, and writes support byte strobes.
- Contains a start/busy/done sequencer with a completion timeout and an interrupt output.
- Sits between the AMBA slave front-end and the adder datapath.

Parameters:
- DATA_W, 32, register/data width; multiple of 8, minimum 32.
- ADDR_W, 32, width of the word-index address buses.
- N_OPS, 2, number of operand registers; range 1..8.
- TIMEOUT, 16, max BUSY cycles waiting for i_result_valid; range 2..255.
- ID_VALUE, 32'hADD0_0002, constant returned by the ID register.

Ports:
- ACLK  in  1  clock.
- ARSTn  in  1  reset.
- i_en_amba_write  in  1  write enable, one write per asserted cycle.
- i_addr_wc  in  ADDR_W  write word index.
- i_data_wc  in  DATA_W  write data.
- i_wstrb  in  DATA_W/8  byte write strobes.
- i_addr_rc  in  ADDR_W  read word index.
- o_data_rc  out  DATA_W  read data, combinational.
- o_operands  out  N_OPS*DATA_W  operand k on bits [k*DATA_W +: DATA_W].
- o_start  out  1  single-cycle start pulse to the datapath.
- o_busy  out  1  high while state is BUSY.
- i_result_valid  in  1  datapath result qualifier.
- i_result  in  DATA_W  datapath result.
- o_irq  out  1  STATUS.done & CTRL.irq_en, level.

Behaviour:
- Reset ARSTn, synchronous, active-low; clock ACLK.
- On reset: all registers 0, state IDLE, timeout counter 0. Therefore o_start=0, o_busy=0, o_irq=0, o_operands=0.
- Reset mid-operation aborts: returns to IDLE immediately, no done or err.

Register map (word index):
- 0..N_OPS-1: OPk, RW.
- N_OPS: RESULT, RO.
- N_OPS+1: CTRL.
  - bit0 start: write-1 triggers, always reads 0.
  - bit1 irq_en: RW.
  - Other bits read 0.
- N_OPS+2: STATUS.
  - bit0 busy: RO.
  - bit1 done: W1C.
  - bit2 err: W1C.
  - Other bits read 0.
- N_OPS+3: ID, RO, reads ID_VALUE.
- Index >= N_OPS+4 reads 0.

Writes:
- A write takes effect on the next ACLK edge.
- Only bytes with i_wstrb set are updated. For CTRL and STATUS, strobe byte 0 gates bits 0..2.
- A write to RO or out-of-range indices is dropped and sets err.
- A write to OPk while BUSY is dropped and sets err, so operands stay stable during computation.

Sequencer, states IDLE and BUSY:
- IDLE -> BUSY when a CTRL write with start=1 (strobe 0 set) occurs. With the write in cycle t:
  - o_start=1 for exactly cycle t+1.
  - o_busy=1 from t+1.
  - done is cleared at t+1.
- A start write while BUSY is ignored and sets err; irq_en is still updated.
- In BUSY, i_result_valid=1 in cycle k:
  - RESULT <= i_result and done <= 1 at k+1.
  - State is IDLE at k+1.
- Timeout: the counter increments each BUSY cycle. If TIMEOUT BUSY cycles elapse with no valid:
  - err <= 1, state -> IDLE.
  - RESULT and done are unchanged.
- If valid arrives on the same cycle as the timeout, valid wins.
- i_result_valid in IDLE is ignored.

Simultaneous events:
- Hardware set of done/err in the same cycle as a W1C of that bit: the set wins.

Decomposition:
- Package adder_csr_pkg holds:
  - state enum (IDLE, BUSY);
  - CTRL/STATUS bit-position localparams;
  - register-offset helper functions relative to N_OPS.
- Sub-module adder_csr_seq holds the FSM, timeout counter, start pulse and done/err set logic.
- Top-level adder_csr_bank holds the register array, strobe merge, address decode and read mux.

Test Plan:
- Reset, then read all indices 0..7 (N_OPS=2) -> 0 everywhere except index 5 = 32'hADD0_0002; o_irq=0, o_busy=0.
- Write OP0=5 with wstrb=4'hF, then OP1=32'h1234_5678 with wstrb=4'b0010 -> OP1 reads 32'h0000_5600; o_operands[63:32] matches.
- Write CTRL=3; drive i_result_valid with i_result=9 three cycles after o_start:
  - o_start high for exactly 1 cycle;
  - o_busy high for 3 cycles;
  - RESULT=9, STATUS=2, o_irq=1.
  - Then write STATUS=2 -> o_irq=0.
- Start with no result valid -> after 16 BUSY cycles, STATUS.err=1, done=0, busy=0; a late valid is ignored and RESULT is unchanged.
- While BUSY, write OP0=7 and CTRL=1 -> OP0 unchanged, err=1, no second o_start.
- Write to index 2 (RESULT) and index 9 -> err=1, contents unchanged. W1C of err in the same cycle as a new error -> err remains 1.

Source files
------------

// File: rtl/adder_csr_pkg.sv
// Shared types, register bit positions and register-offset helpers for the adder CSR bank.
// Offsets of the fixed registers follow the N_OPS operand slots.
package adder_csr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } seq_state_e;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    localparam int SEQ_CNT_W = 8;

    function automatic int result_idx(input int n_ops);
        return n_ops;
    endfunction

    function automatic int ctrl_idx(input int n_ops);
        return n_ops + 1;
    endfunction

    function automatic int status_idx(input int n_ops);
        return n_ops + 2;
    endfunction

    function automatic int id_idx(input int n_ops);
        return n_ops + 3;
    endfunction

    function automatic int first_unmapped_idx(input int n_ops);
        return n_ops + 4;
    endfunction

endpackage

// File: rtl/adder_csr_seq.sv
// Start/busy/done sequencer: IDLE/BUSY FSM, completion timeout, start pulse,
// result capture and the done/err sticky flags.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a start write; i_result_valid ignored
//   ST_BUSY | datapath running; waiting for result valid or timeout
module adder_csr_seq
    import adder_csr_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              ACLK,
    input  logic              ARSTn,
    input  logic              start_req,
    input  logic              err_req,
    input  logic              w1c_done,
    input  logic              w1c_err,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result,
    output logic              start_pulse,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result_q
);

    seq_state_e           state;
    logic [SEQ_CNT_W-1:0] cnt;
    logic                 timeout_hit;

    assign timeout_hit = (cnt == SEQ_CNT_W'(TIMEOUT - 1));
    assign busy        = (state == ST_BUSY);

    // Sticky flags: W1C is applied first so a hardware set in the same cycle wins.
    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            start_pulse <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            result_q    <= '0;
        end else begin
            start_pulse <= 1'b0;

            if (w1c_done) begin
                done <= 1'b0;
            end
            if (w1c_err) begin
                err <= 1'b0;
            end
            if (err_req) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state       <= ST_BUSY;
                        cnt         <= '0;
                        start_pulse <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (start_req) begin
                        err <= 1'b1;
                    end
                    if (result_valid) begin
                        result_q <= result;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                        cnt      <= '0;
                    end else if (timeout_hit) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adder_csr_bank.sv
// Control/status register bank for the adder: operand registers with byte strobes,
// RESULT/CTRL/STATUS/ID decode, combinational read mux and the sequencer instance.
module adder_csr_bank
    import adder_csr_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter int          N_OPS    = 2,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ID_VALUE = 32'hADD0_0002
) (
    input  logic                    ACLK,
    input  logic                    ARSTn,
    input  logic                    i_en_amba_write,
    input  logic [ADDR_W-1:0]       i_addr_wc,
    input  logic [DATA_W-1:0]       i_data_wc,
    input  logic [DATA_W/8-1:0]     i_wstrb,
    input  logic [ADDR_W-1:0]       i_addr_rc,
    output logic [DATA_W-1:0]       o_data_rc,
    output logic [N_OPS*DATA_W-1:0] o_operands,
    output logic                    o_start,
    output logic                    o_busy,
    input  logic                    i_result_valid,
    input  logic [DATA_W-1:0]       i_result,
    output logic                    o_irq
);

    localparam int N_BYTES     = DATA_W / 8;
    localparam int IDX_RESULT  = result_idx(N_OPS);
    localparam int IDX_CTRL    = ctrl_idx(N_OPS);
    localparam int IDX_STATUS  = status_idx(N_OPS);
    localparam int IDX_ID      = id_idx(N_OPS);
    localparam int IDX_UNMAPPED = first_unmapped_idx(N_OPS);

    logic [DATA_W-1:0] op_q [N_OPS];
    logic              irq_en_q;

    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result_q;

    logic wr_is_op;
    logic wr_is_result;
    logic wr_is_ctrl;
    logic wr_is_status;
    logic wr_is_id;
    logic wr_unmapped;
    logic wr_op_ok;
    logic wr_err;
    logic wr_ctrl_b0;
    logic wr_status_b0;
    logic start_req;
    logic w1c_done;
    logic w1c_err;

    always_comb begin
        wr_is_op     = (i_addr_wc <  ADDR_W'(N_OPS));
        wr_is_result = (i_addr_wc == ADDR_W'(IDX_RESULT));
        wr_is_ctrl   = (i_addr_wc == ADDR_W'(IDX_CTRL));
        wr_is_status = (i_addr_wc == ADDR_W'(IDX_STATUS));
        wr_is_id     = (i_addr_wc == ADDR_W'(IDX_ID));
        wr_unmapped  = (i_addr_wc >= ADDR_W'(IDX_UNMAPPED));
    end

    // Operand writes during BUSY are refused so the datapath sees stable inputs.
    assign wr_op_ok     = i_en_amba_write && wr_is_op && !busy;
    assign wr_err       = i_en_amba_write &&
                          (wr_is_result || wr_is_id || wr_unmapped || (wr_is_op && busy));
    assign wr_ctrl_b0   = i_en_amba_write && wr_is_ctrl && i_wstrb[0];
    assign wr_status_b0 = i_en_amba_write && wr_is_status && i_wstrb[0];
    assign start_req    = wr_ctrl_b0 && i_data_wc[CTRL_START_BIT];
    assign w1c_done     = wr_status_b0 && i_data_wc[STATUS_DONE_BIT];
    assign w1c_err      = wr_status_b0 && i_data_wc[STATUS_ERR_BIT];

    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            for (int k = 0; k < N_OPS; k++) begin
                op_q[k] <= '0;
            end
            irq_en_q <= 1'b0;
        end else begin
            if (wr_op_ok) begin
                for (int k = 0; k < N_OPS; k++) begin
                    if (i_addr_wc == ADDR_W'(k)) begin
                        for (int b = 0; b < N_BYTES; b++) begin
                            if (i_wstrb[b]) begin
                                op_q[k][b*8 +: 8] <= i_data_wc[b*8 +: 8];
                            end
                        end
                    end
                end
            end
            if (wr_ctrl_b0) begin
                irq_en_q <= i_data_wc[CTRL_IRQ_EN_BIT];
            end
        end
    end

    always_comb begin
        o_data_rc = '0;
        for (int k = 0; k < N_OPS; k++) begin
            if (i_addr_rc == ADDR_W'(k)) begin
                o_data_rc = op_q[k];
            end
        end
        if (i_addr_rc == ADDR_W'(IDX_RESULT)) begin
            o_data_rc = result_q;
        end
        if (i_addr_rc == ADDR_W'(IDX_CTRL)) begin
            o_data_rc[CTRL_IRQ_EN_BIT] = irq_en_q;
        end
        if (i_addr_rc == ADDR_W'(IDX_STATUS)) begin
            o_data_rc[STATUS_BUSY_BIT] = busy;
            o_data_rc[STATUS_DONE_BIT] = done;
            o_data_rc[STATUS_ERR_BIT]  = err;
        end
        if (i_addr_rc == ADDR_W'(IDX_ID)) begin
            o_data_rc = DATA_W'(ID_VALUE);
        end
    end

    for (genvar k = 0; k < N_OPS; k++) begin : g_operands
        assign o_operands[k*DATA_W +: DATA_W] = op_q[k];
    end

    assign o_busy = busy;
    assign o_irq  = done && irq_en_q;

    adder_csr_seq #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_seq (
        .ACLK         (ACLK),
        .ARSTn        (ARSTn),
        .start_req    (start_req),
        .err_req      (wr_err),
        .w1c_done     (w1c_done),
        .w1c_err      (w1c_err),
        .result_valid (i_result_valid),
        .result       (i_result),
        .start_pulse  (o_start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .result_q     (result_q)
    );

endmodule

// File: tb/tb_adder_csr_bank.sv
// Self-checking bench for adder_csr_bank (default parameters: N_OPS=2, TIMEOUT=16).
module tb_adder_csr_bank;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int N_OPS   = 2;
    localparam int TIMEOUT = 16;

    localparam int A_RESULT = 2;
    localparam int A_CTRL   = 3;
    localparam int A_STATUS = 4;
    localparam int A_ID     = 5;

    logic                    ACLK;
    logic                    ARSTn;
    logic                    i_en_amba_write;
    logic [ADDR_W-1:0]       i_addr_wc;
    logic [DATA_W-1:0]       i_data_wc;
    logic [DATA_W/8-1:0]     i_wstrb;
    logic [ADDR_W-1:0]       i_addr_rc;
    logic [DATA_W-1:0]       o_data_rc;
    logic [N_OPS*DATA_W-1:0] o_operands;
    logic                    o_start;
    logic                    o_busy;
    logic                    i_result_valid;
    logic [DATA_W-1:0]       i_result;
    logic                    o_irq;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt  = 0;
    int start_cnt = 0;
    int busy_base;
    int start_base;
    logic [63:0] exp_q [$];

    adder_csr_bank dut (
        .ACLK           (ACLK),
        .ARSTn          (ARSTn),
        .i_en_amba_write(i_en_amba_write),
        .i_addr_wc      (i_addr_wc),
        .i_data_wc      (i_data_wc),
        .i_wstrb        (i_wstrb),
        .i_addr_rc      (i_addr_rc),
        .o_data_rc      (o_data_rc),
        .o_operands     (o_operands),
        .o_start        (o_start),
        .o_busy         (o_busy),
        .i_result_valid (i_result_valid),
        .i_result       (i_result),
        .o_irq          (o_irq)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (o_busy)  busy_cnt++;
        if (o_start) start_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_reg(input int addr, input logic [31:0] data, input logic [3:0] strb);
        i_en_amba_write = 1'b1;
        i_addr_wc       = ADDR_W'(addr);
        i_data_wc       = data;
        i_wstrb         = strb;
        tick();
        i_en_amba_write = 1'b0;
        i_wstrb         = '0;
    endtask

    task automatic read_exp(input string tag, input int addr, input logic [31:0] exp);
        logic [63:0] e;
        exp_q.push_back({32'h0, exp});
        i_addr_rc = ADDR_W'(addr);
        #1;
        e = exp_q.pop_front();
        chk(tag, {32'h0, o_data_rc}, e);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (o_busy && n < max_cycles) begin
            tick();
            n++;
        end
        if (o_busy) chk("wait_idle_bound", 64'(o_busy), 64'd0);
    endtask

    task automatic snap();
        busy_base  = busy_cnt;
        start_base = start_cnt;
    endtask

    initial begin
        logic [31:0] exp_id;
        ARSTn           = 1'b0;
        i_en_amba_write = 1'b0;
        i_addr_wc       = '0;
        i_data_wc       = '0;
        i_wstrb         = '0;
        i_addr_rc       = '0;
        i_result_valid  = 1'b0;
        i_result        = '0;
        exp_id          = 32'hADD0_0002;
        repeat (3) tick();
        ARSTn = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) read_exp($sformatf("rst_rd%0d", a), a, (a == A_ID) ? exp_id : 32'h0);
        chk("rst_irq", 64'(o_irq), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_start", 64'(o_start), 64'd0);
        chk("rst_operands", 64'(o_operands), 64'd0);

        // Operand writes with strobes
        write_reg(0, 32'h0000_0005, 4'hF);
        write_reg(1, 32'h1234_5678, 4'b0010);
        read_exp("op0", 0, 32'h5);
        read_exp("op1_strb", 1, 32'h0000_5600);
        chk("operands_hi", 64'(o_operands[63:32]), 64'h0000_5600);
        chk("operands_lo", 64'(o_operands[31:0]), 64'h5);

        // Normal operation with irq
        snap();
        write_reg(A_CTRL, 32'h3, 4'hF);
        chk("go_start", 64'(o_start), 64'd1);
        chk("go_busy", 64'(o_busy), 64'd1);
        read_exp("ctrl_rd", A_CTRL, 32'h2);
        tick();
        chk("go_start_drop", 64'(o_start), 64'd0);
        tick();
        i_result_valid = 1'b1;
        i_result       = 32'h9;
        tick();
        i_result_valid = 1'b0;
        chk("go_busy_cycles", 64'(busy_cnt - busy_base), 64'd3);
        chk("go_start_cycles", 64'(start_cnt - start_base), 64'd1);
        chk("go_idle", 64'(o_busy), 64'd0);
        chk("go_irq", 64'(o_irq), 64'd1);
        read_exp("go_result", A_RESULT, 32'h9);
        read_exp("go_status", A_STATUS, 32'h2);
        write_reg(A_STATUS, 32'h2, 4'hF);
        chk("w1c_irq", 64'(o_irq), 64'd0);
        read_exp("w1c_status", A_STATUS, 32'h0);

        // Timeout, then a late valid
        snap();
        write_reg(A_CTRL, 32'h1, 4'hF);
        wait_idle(40);
        chk("to_busy_cycles", 64'(busy_cnt - busy_base), 64'(TIMEOUT));
        read_exp("to_status", A_STATUS, 32'h4);
        i_result_valid = 1'b1;
        i_result       = 32'hDEAD_BEEF;
        tick();
        i_result_valid = 1'b0;
        read_exp("late_result", A_RESULT, 32'h9);
        read_exp("late_status", A_STATUS, 32'h4);
        write_reg(A_STATUS, 32'h4, 4'hF);
        read_exp("to_clr", A_STATUS, 32'h0);

        // done set collides with W1C of done
        write_reg(A_CTRL, 32'h1, 4'hF);
        i_result_valid = 1'b1;
        i_result       = 32'h1111;
        write_reg(A_STATUS, 32'h2, 4'hF);
        i_result_valid = 1'b0;
        read_exp("done_race_status", A_STATUS, 32'h2);
        read_exp("done_race_result", A_RESULT, 32'h1111);
        write_reg(A_STATUS, 32'h2, 4'hF);

        // Writes while BUSY
        snap();
        write_reg(A_CTRL, 32'h1, 4'hF);
        write_reg(0, 32'h7, 4'hF);
        write_reg(A_CTRL, 32'h1, 4'hF);
        i_result_valid = 1'b1;
        i_result       = 32'h5 + 32'h5600;
        tick();
        i_result_valid = 1'b0;
        chk("bw_busy_cycles", 64'(busy_cnt - busy_base), 64'd3);
        chk("bw_one_start", 64'(start_cnt - start_base), 64'd1);
        read_exp("bw_op0", 0, 32'h5);
        chk("bw_operands", 64'(o_operands[31:0]), 64'h5);
        read_exp("bw_status", A_STATUS, 32'h6);
        read_exp("bw_result", A_RESULT, 32'h5605);
        chk("bw_irq_off", 64'(o_irq), 64'd0);
        write_reg(A_STATUS, 32'h6, 4'hF);

        // Read-only and unmapped writes
        write_reg(A_RESULT, 32'hFFFF_FFFF, 4'hF);
        read_exp("ro_result", A_RESULT, 32'h5605);
        read_exp("ro_err", A_STATUS, 32'h4);
        write_reg(A_STATUS, 32'h4, 4'hF);
        write_reg(9, 32'hFFFF_FFFF, 4'hF);
        read_exp("oor_err", A_STATUS, 32'h4);
        read_exp("oor_rd", 9, 32'h0);
        write_reg(A_STATUS, 32'h4, 4'hF);
        write_reg(A_ID, 32'h0, 4'hF);
        read_exp("id_err", A_STATUS, 32'h4);
        read_exp("id_keep", A_ID, exp_id);
        write_reg(A_STATUS, 32'h4, 4'hF);
        read_exp("err_clr", A_STATUS, 32'h0);

        // W1C of err in the timeout cycle
        write_reg(A_CTRL, 32'h1, 4'hF);
        repeat (TIMEOUT - 1) tick();
        chk("race_last_busy", 64'(o_busy), 64'd1);
        write_reg(A_STATUS, 32'h4, 4'hF);
        chk("race_idle", 64'(o_busy), 64'd0);
        read_exp("err_race_status", A_STATUS, 32'h4);
        write_reg(A_STATUS, 32'h4, 4'hF);

        // Reset during BUSY
        write_reg(A_CTRL, 32'h3, 4'hF);
        chk("pre_rst_busy", 64'(o_busy), 64'd1);
        ARSTn = 1'b0;
        tick();
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_start", 64'(o_start), 64'd0);
        chk("mid_rst_irq", 64'(o_irq), 64'd0);
        read_exp("mid_rst_status", A_STATUS, 32'h0);
        read_exp("mid_rst_ctrl", A_CTRL, 32'h0);
        read_exp("mid_rst_result", A_RESULT, 32'h0);
        chk("mid_rst_operands", 64'(o_operands), 64'd0);
        ARSTn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not terminate");
    end

endmodule
